// File: rtl/pattern_walker_pkg.sv
// Shared definitions for the coordinate walker: FSM states, walk order encodings
// and default coordinate formats reused by the solver cores.
package pattern_walker_pkg;

  localparam int DEF_WIDTH = 27;
  localparam int DEF_FRAC  = 23;
  localparam int DEF_IDX_W = 12;

  localparam logic ORDER_RASTER   = 1'b0;
  localparam logic ORDER_COLMAJOR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_EMIT = 2'd2,
    ST_FIN  = 2'd3
  } walk_state_t;

  function automatic logic fast_is_y(input logic order);
    return order == ORDER_COLMAJOR;
  endfunction

endpackage

// File: rtl/pattern_walker_axis_stepper.sv
// One walk axis: position and pixel index plus look-ahead limit flags computed
// with enough headroom that a step past the limit can never wrap.
module pattern_walker_axis_stepper #(
  parameter int WIDTH = 27,
  parameter int IDX_W = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    advance,
  input  logic                    rewind,
  input  logic signed [WIDTH-1:0] load_pos,
  input  logic signed [WIDTH-1:0] load_stride,
  input  logic signed [WIDTH-1:0] load_limit,
  input  logic [IDX_W-1:0]        load_idx,
  input  logic [IDX_W-1:0]        load_idx_step,
  output logic signed [WIDTH-1:0] pos,
  output logic [IDX_W-1:0]        idx,
  output logic signed [WIDTH-1:0] next_pos,
  output logic [IDX_W-1:0]        next_idx,
  output logic signed [WIDTH-1:0] origin,
  output logic [IDX_W-1:0]        origin_idx,
  output logic                    over,
  output logic                    exceed,
  output logic                    exceed2,
  output logic                    exceed_rw
);

  logic signed [WIDTH-1:0]   stride;
  logic signed [WIDTH-1:0]   limit;
  logic [IDX_W-1:0]          idx_step;
  logic signed [WIDTH+1:0]   pos_e, stride_e, limit_e, origin_e;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos        <= '0;
      idx        <= '0;
      origin     <= '0;
      origin_idx <= '0;
      stride     <= '0;
      limit      <= '0;
      idx_step   <= '0;
    end else if (load) begin
      pos        <= load_pos;
      idx        <= load_idx;
      origin     <= load_pos;
      origin_idx <= load_idx;
      stride     <= load_stride;
      limit      <= load_limit;
      idx_step   <= load_idx_step;
    end else if (rewind) begin
      pos <= origin;
      idx <= origin_idx;
    end else if (advance) begin
      pos <= next_pos;
      idx <= next_idx;
    end
  end

  assign pos_e    = {{2{pos[WIDTH-1]}}, pos};
  assign stride_e = {{2{stride[WIDTH-1]}}, stride};
  assign limit_e  = {{2{limit[WIDTH-1]}}, limit};
  assign origin_e = {{2{origin[WIDTH-1]}}, origin};

  assign next_pos  = pos + stride;
  assign next_idx  = idx + idx_step;
  assign over      = pos_e > limit_e;
  assign exceed    = (pos_e + stride_e) > limit_e;
  // Two steps ahead lets the top register coord_last for the tuple it is loading.
  assign exceed2   = (pos_e + stride_e + stride_e) > limit_e;
  assign exceed_rw = (origin_e + stride_e) > limit_e;

endmodule

// File: rtl/pattern_walker.sv
// Interleaved raster / column-major coordinate walker with valid/ready output,
// abort, empty-region detection and a done pulse.
module pattern_walker
  import pattern_walker_pkg::*;
#(
  parameter int CORE_ID    = 0,
  parameter int CORE_COUNT = 1,
  parameter int WIDTH      = 27,
  parameter int IDX_W      = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    col_major,
  input  logic signed [WIDTH-1:0] min_x,
  input  logic signed [WIDTH-1:0] min_y,
  input  logic signed [WIDTH-1:0] max_x,
  input  logic signed [WIDTH-1:0] max_y,
  input  logic signed [WIDTH-1:0] dx,
  input  logic signed [WIDTH-1:0] dy,
  output logic                    coord_valid,
  input  logic                    coord_ready,
  output logic signed [WIDTH-1:0] coord_x,
  output logic signed [WIDTH-1:0] coord_y,
  output logic [IDX_W-1:0]        pixel_col,
  output logic [IDX_W-1:0]        pixel_row,
  output logic                    coord_last,
  output logic                    busy,
  output logic                    done
);

  localparam logic signed [WIDTH-1:0] ID_MUL  = WIDTH'(CORE_ID);
  localparam logic signed [WIDTH-1:0] CNT_MUL = WIDTH'(CORE_COUNT);
  localparam logic [IDX_W-1:0]        ID_IDX  = IDX_W'(CORE_ID);
  localparam logic [IDX_W-1:0]        CNT_IDX = IDX_W'(CORE_COUNT);

  walk_state_t state;
  logic        order;

  logic signed [WIDTH-1:0] f_min_sel, f_max_sel, f_step_sel, s_min_sel, s_max_sel, s_step_sel;
  logic                    load_go, handshake, f_adv, f_rw, s_adv, fin_next, n_last;
  logic signed [WIDTH-1:0] nf_pos, ns_pos, tx, ty;
  logic [IDX_W-1:0]        nf_idx, ns_idx, tcol, trow;

  logic signed [WIDTH-1:0] f_pos, f_next, f_origin, s_pos, s_next, s_origin;
  logic [IDX_W-1:0]        f_idx, f_next_idx, f_origin_idx, s_idx, s_next_idx, s_origin_idx;
  logic                    f_over, f_exceed, f_exceed2, f_exceed_rw;
  logic                    s_over, s_exceed, s_exceed2, s_exceed_rw;
  logic                    unused_slow;

  assign f_min_sel  = fast_is_y(col_major) ? min_y : min_x;
  assign f_max_sel  = fast_is_y(col_major) ? max_y : max_x;
  assign f_step_sel = fast_is_y(col_major) ? dy : dx;
  assign s_min_sel  = fast_is_y(col_major) ? min_x : min_y;
  assign s_max_sel  = fast_is_y(col_major) ? max_x : max_y;
  assign s_step_sel = fast_is_y(col_major) ? dx : dy;
  assign load_go    = (state == ST_IDLE) && start;
  assign handshake  = (state == ST_EMIT) && coord_valid && coord_ready;
  assign unused_slow = ^{s_origin, s_origin_idx, s_exceed_rw};

  pattern_walker_axis_stepper #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_fast (
    .clock(clock), .reset(reset), .load(load_go), .advance(f_adv), .rewind(f_rw),
    .load_pos(f_min_sel + ID_MUL * f_step_sel), .load_stride(CNT_MUL * f_step_sel),
    .load_limit(f_max_sel), .load_idx(ID_IDX), .load_idx_step(CNT_IDX),
    .pos(f_pos), .idx(f_idx), .next_pos(f_next), .next_idx(f_next_idx),
    .origin(f_origin), .origin_idx(f_origin_idx), .over(f_over), .exceed(f_exceed),
    .exceed2(f_exceed2), .exceed_rw(f_exceed_rw)
  );

  pattern_walker_axis_stepper #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_slow (
    .clock(clock), .reset(reset), .load(load_go), .advance(s_adv), .rewind(1'b0),
    .load_pos(s_min_sel), .load_stride(s_step_sel), .load_limit(s_max_sel),
    .load_idx({IDX_W{1'b0}}), .load_idx_step(IDX_W'(1)),
    .pos(s_pos), .idx(s_idx), .next_pos(s_next), .next_idx(s_next_idx),
    .origin(s_origin), .origin_idx(s_origin_idx), .over(s_over), .exceed(s_exceed),
    .exceed2(s_exceed2), .exceed_rw(s_exceed_rw)
  );

  // Choose the next tuple and its last flag; without a handshake this is the INIT tuple.
  always_comb begin
    f_adv    = 1'b0;
    f_rw     = 1'b0;
    s_adv    = 1'b0;
    fin_next = 1'b0;
    nf_pos   = f_pos;
    nf_idx   = f_idx;
    ns_pos   = s_pos;
    ns_idx   = s_idx;
    n_last   = f_exceed & s_exceed;
    if (handshake && !abort) begin
      if (!f_exceed) begin
        f_adv  = 1'b1;
        nf_pos = f_next;
        nf_idx = f_next_idx;
        n_last = f_exceed2 & s_exceed;
      end else if (!s_exceed) begin
        f_rw   = 1'b1;
        s_adv  = 1'b1;
        nf_pos = f_origin;
        nf_idx = f_origin_idx;
        ns_pos = s_next;
        ns_idx = s_next_idx;
        n_last = f_exceed_rw & s_exceed2;
      end else begin
        fin_next = 1'b1;
      end
    end else begin
      fin_next = 1'b0;
    end
  end

  // Map fast/slow back onto x/y; pixel_col always follows x.
  always_comb begin
    if (fast_is_y(order)) begin
      tx = ns_pos; ty = nf_pos; tcol = ns_idx; trow = nf_idx;
    end else begin
      tx = nf_pos; ty = ns_pos; tcol = nf_idx; trow = ns_idx;
    end
  end

  // Walk FSM with registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      order       <= ORDER_RASTER;
      coord_valid <= 1'b0;
      coord_last  <= 1'b0;
      coord_x     <= '0;
      coord_y     <= '0;
      pixel_col   <= '0;
      pixel_row   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            order <= col_major;
            busy  <= 1'b1;
            state <= ST_INIT;
          end
        end
        ST_INIT, ST_EMIT: begin
          if (abort || fin_next || (state == ST_INIT && (f_over || s_over))) begin
            state       <= ST_FIN;
            coord_valid <= 1'b0;
            coord_last  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else if (state == ST_INIT || handshake) begin
            state       <= ST_EMIT;
            coord_valid <= 1'b1;
            coord_last  <= n_last;
            coord_x     <= tx;
            coord_y     <= ty;
            pixel_col   <= tcol;
            pixel_row   <= trow;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_walker.sv
// Randomised bench for pattern_walker: two interleaved walkers (ID0/CNT1, ID1/CNT2)
// checked against a nested-loop model of the region walk.
module tb_pattern_walker;

  localparam int W  = 27;
  localparam int IW = 12;

  logic clock = 1'b0;
  logic reset, start, abort, col_major, coord_ready;
  logic signed [W-1:0] min_x, min_y, max_x, max_y, dx, dy;
  logic v[2], lst[2], bsy[2], dn[2];
  logic signed [W-1:0] cx[2], cy[2];
  logic [IW-1:0] pc[2], pr[2];

  always #5 clock = ~clock;

  pattern_walker #(.CORE_ID(0), .CORE_COUNT(1), .WIDTH(W), .IDX_W(IW)) dut0 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .col_major(col_major),
    .min_x(min_x), .min_y(min_y), .max_x(max_x), .max_y(max_y), .dx(dx), .dy(dy),
    .coord_valid(v[0]), .coord_ready(coord_ready), .coord_x(cx[0]), .coord_y(cy[0]),
    .pixel_col(pc[0]), .pixel_row(pr[0]), .coord_last(lst[0]), .busy(bsy[0]), .done(dn[0])
  );

  pattern_walker #(.CORE_ID(1), .CORE_COUNT(2), .WIDTH(W), .IDX_W(IW)) dut1 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .col_major(col_major),
    .min_x(min_x), .min_y(min_y), .max_x(max_x), .max_y(max_y), .dx(dx), .dy(dy),
    .coord_valid(v[1]), .coord_ready(coord_ready), .coord_x(cx[1]), .coord_y(cy[1]),
    .pixel_col(pc[1]), .pixel_row(pr[1]), .coord_last(lst[1]), .busy(bsy[1]), .done(dn[1])
  );

  typedef struct {longint x; longint y; int col; int row; bit last;} tup_t;
  tup_t q0[$];
  tup_t q1[$];
  int   errors = 0;
  int   checks = 0;
  bit   pend[2], stalled[2], last_hs[2];
  int   hs[2], done_cnt[2];
  longint prev_x[2];
  int     prev_col[2];

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference walk: nested loops over the slow and fast axes of the region.
  task automatic build(input int id, input int cnt, input longint mnx, input longint mny,
                       input longint mxx, input longint mxy, input longint ddx,
                       input longint ddy, input bit cm);
    longint fmin, fmax, fst, smin, smax, sst;
    tup_t t;
    int r, c;
    fmin = cm ? mny : mnx; fmax = cm ? mxy : mxx; fst = cm ? ddy : ddx;
    smin = cm ? mnx : mny; smax = cm ? mxx : mxy; sst = cm ? ddx : ddy;
    r = 0;
    for (longint s = smin; s <= smax; s += sst) begin
      c = id;
      for (longint f = fmin + id * fst; f <= fmax; f += cnt * fst) begin
        t.x = cm ? s : f;
        t.y = cm ? f : s;
        t.col = (cm ? r : c) % 4096;
        t.row = (cm ? c : r) % 4096;
        t.last = 1'b0;
        if (id == 0) q0.push_back(t); else q1.push_back(t);
        c += cnt;
      end
      r++;
    end
    if (id == 0 && q0.size() > 0) q0[q0.size()-1].last = 1'b1;
    if (id == 1 && q1.size() > 0) q1[q1.size()-1].last = 1'b1;
  endtask

  task automatic observe(input int i, input int cyc, input bit empty, input bit ab);
    tup_t t;
    bit have;
    last_hs[i] = 1'b0;
    if (pend[i]) begin
      hs[i]++;
      if (i == 0 && q0.size() > 0) begin last_hs[i] = q0[0].last; void'(q0.pop_front()); end
      if (i == 1 && q1.size() > 0) begin last_hs[i] = q1[0].last; void'(q1.pop_front()); end
    end
    pend[i] = 1'b0;
    if (cyc == 1) check($sformatf("d%0d_lat_valid_low", i), v[i], 0);
    if (cyc == 2 && !empty) check($sformatf("d%0d_lat_valid_high", i), v[i], 1);
    if (stalled[i]) begin
      check($sformatf("d%0d_stall_valid", i), v[i], 1);
      check($sformatf("d%0d_stall_x", i), cx[i], prev_x[i]);
      check($sformatf("d%0d_stall_col", i), pc[i], prev_col[i]);
    end
    if (v[i]) begin
      have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
      check($sformatf("d%0d_tuple_expected", i), have, 1);
      if (have) begin
        t = (i == 0) ? q0[0] : q1[0];
        check($sformatf("d%0d_x", i), cx[i], t.x);
        check($sformatf("d%0d_y", i), cy[i], t.y);
        check($sformatf("d%0d_col", i), pc[i], t.col);
        check($sformatf("d%0d_row", i), pr[i], t.row);
        check($sformatf("d%0d_last", i), lst[i], t.last);
      end
    end
    if (dn[i]) begin
      done_cnt[i]++;
      check($sformatf("d%0d_done_busy", i), bsy[i], 0);
      check($sformatf("d%0d_done_valid", i), v[i], 0);
      if (empty) check($sformatf("d%0d_empty_done_time", i), cyc, 2);
      else if (!ab) check($sformatf("d%0d_done_after_last", i), last_hs[i], 1);
    end
  endtask

  task automatic run_walk(input longint mnx, input longint mny, input longint mxx,
                          input longint mxy, input longint ddx, input longint ddy,
                          input bit cm, input int ready_pct, input int abort_after,
                          input int reset_at);
    bit e0, e1, aborted, finished, was_reset;
    int cyc;
    q0.delete(); q1.delete();
    build(0, 1, mnx, mny, mxx, mxy, ddx, ddy, cm);
    build(1, 2, mnx, mny, mxx, mxy, ddx, ddy, cm);
    e0 = (q0.size() == 0); e1 = (q1.size() == 0);
    @(negedge clock); @(negedge clock);
    min_x = W'(mnx); min_y = W'(mny); max_x = W'(mxx); max_y = W'(mxy);
    dx = W'(ddx); dy = W'(ddy); col_major = cm;
    start = 1'b1; abort = 1'b0; coord_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; stalled[i] = 0; hs[i] = 0; done_cnt[i] = 0;
    end
    aborted = 0; finished = 0; was_reset = 0;
    @(negedge clock);
    start = 1'b0;
    for (cyc = 1; cyc <= 3000 && !finished; cyc++) begin
      if (cyc > 1) @(negedge clock);
      observe(0, cyc, e0, aborted | abort);
      observe(1, cyc, e1, aborted | abort);
      if (cyc == 1) begin
        check("d0_busy_after_start", bsy[0], 1);
        check("d1_busy_after_start", bsy[1], 1);
      end
      if (abort) begin
        check("abort_valid_drop", v[0], 0);
        check("abort_done", dn[0], 1);
        check("abort_busy", bsy[0], 0);
        abort = 1'b0;
        aborted = 1'b1;
        q0.delete(); q1.delete();
      end
      if (reset_at > 0 && hs[0] == reset_at) begin
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
          check($sformatf("d%0d_rst_outs", i), {v[i], lst[i], bsy[i], dn[i]}, 0);
          check($sformatf("d%0d_rst_coords", i), {cx[i], cy[i], pc[i], pr[i]}, 0);
        end
        @(negedge clock);
        reset = 1'b0;
        was_reset = 1'b1;
        finished = 1'b1;
      end else begin
        finished = (done_cnt[0] > 0) && (done_cnt[1] > 0);
        coord_ready = ($urandom_range(0, 99) < ready_pct);
        if (abort_after > 0 && hs[0] == abort_after && !aborted) begin
          abort = 1'b1;
          coord_ready = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
          pend[i] = v[i] & coord_ready;
          stalled[i] = v[i] & !coord_ready & !abort;
          prev_x[i] = cx[i];
          prev_col[i] = pc[i];
        end
      end
    end
    abort = 1'b0;
    coord_ready = 1'b0;
    if (!finished) check("walk_timeout", 0, 1);
    if (!was_reset) begin
      check("d0_done_once", done_cnt[0], 1);
      check("d1_done_once", done_cnt[1], 1);
      check("d0_all_consumed", q0.size(), 0);
      check("d1_all_consumed", q1.size(), 0);
    end
  endtask

  initial begin
    longint mnx, mny, mxx, mxy, ddx, ddy;
    reset = 1'b1; start = 1'b0; abort = 1'b0; col_major = 1'b0; coord_ready = 1'b0;
    min_x = '0; min_y = '0; max_x = '0; max_y = '0; dx = '0; dy = '0;
    @(negedge clock); @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("d%0d_reset_outs", i), {v[i], lst[i], bsy[i], dn[i]}, 0);
      check($sformatf("d%0d_reset_coords", i), {cx[i], cy[i], pc[i], pr[i]}, 0);
    end
    reset = 1'b0;

    run_walk(0, 0, 8, 8, 1, 1, 1'b0, 100, 0, 0);
    run_walk(9, 0, 8, 8, 1, 1, 1'b0, 100, 0, 0);
    run_walk(0, 0, 2, 2, 1, 1, 1'b1, 100, 0, 0);
    run_walk(0, 0, 8, 8, 1, 1, 1'b0, 50, 0, 0);
    run_walk(0, 0, 8, 8, 1, 1, 1'b0, 100, 5, 0);
    run_walk(0, 0, 8, 8, 1, 1, 1'b0, 70, 0, 7);
    run_walk(0, 0, 8, 8, 1, 1, 1'b0, 100, 0, 0);
    run_walk(-5, 3, 4, 2, 3, 1, 1'b0, 100, 0, 0);

    for (int k = 0; k < 8; k++) begin
      ddx = longint'($urandom_range(1, 4));
      ddy = longint'($urandom_range(1, 4));
      mnx = longint'($urandom_range(0, 40)) - 20;
      mny = longint'($urandom_range(0, 40)) - 20;
      mxx = mnx + ddx * longint'($urandom_range(0, 8)) + longint'($urandom_range(0, 3));
      mxy = mny + ddy * longint'($urandom_range(0, 8)) + longint'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) mxy = mny - 1;
      run_walk(mnx, mny, mxx, mxy, ddx, ddy, 1'($urandom_range(0, 1)),
               int'($urandom_range(30, 100)), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
